pe_triplet_feeder: RTL and testbench

Upstream feeder for the PE reducer. Accepts a stream of sparse product entries (3-D output address, weight, activation) over a valid/ready handshake, buffers them in a FIFO, and packs them into groups of three. Each group is issued to the reducer with a one-cycle start pulse and held stable until the reducer reports finish. A flush request pads the final partial group so the reducer accumulates it without error.

---
 rtl/pe_triplet_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_pe_triplet_feeder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_triplet_feeder.sv
//------------------------------------------------------------------------------
// pe_triplet_feeder
//   Buffers sparse product entries (3-D address, weight, activation) in a
//   circular FIFO and issues them to the PE reducer in groups of three.
//   A flush request drains a trailing partial group, padding the empty slots.
//   Optional feature macro: FEEDER_ZERO_SKIP_EN drops entries whose weight or
//   activation is zero after the handshake completes.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_triplet_feeder #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [2:0][6:0]     i_addr,
  input  logic [15:0]         i_w,
  input  logic [15:0]         i_ia,
  input  logic                i_flush,
  output logic                o_start,
  output logic [2:0][6:0]     o_addr [0:2],
  output logic [15:0]         o_w    [0:2],
  output logic [15:0]         o_ia   [0:2],
  input  logic                i_red_finish,
  output logic                o_finish,
  output logic [CW-1:0]       o_count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            flush_pend_q;
  logic            start_q;
  logic            finish_q;

  logic [2:0][6:0] grp_addr_q [0:2];
  logic [15:0]     grp_w_q    [0:2];
  logic [15:0]     grp_ia_q   [0:2];
  logic [2:0][6:0] grp_addr_d [0:2];
  logic [15:0]     grp_w_d    [0:2];
  logic [15:0]     grp_ia_d   [0:2];

  logic [2:0][6:0] mem_addr [0:DEPTH-1];
  logic [15:0]     mem_w    [0:DEPTH-1];
  logic [15:0]     mem_ia   [0:DEPTH-1];

  logic [2:0][6:0] rd_addr [0:2];
  logic [15:0]     rd_w    [0:2];
  logic [15:0]     rd_ia   [0:2];
  logic [2:0][6:0] last_addr;

  logic            accept;
  logic            push;
  logic            flush_eff;
  logic            load;
  logic            fin_fire;
  logic [1:0]      pop_n;

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign o_ready   = i_rst_n && (count_q < CW'(DEPTH)) && !flush_pend_q;
  assign accept    = i_valid && o_ready;
  // A flush arriving this cycle is acted on at once so an empty-FIFO flush
  // finishes on the following cycle.
  assign flush_eff = flush_pend_q || i_flush;

`ifdef FEEDER_ZERO_SKIP_EN
  assign push = accept && (i_w != 16'd0) && (i_ia != 16'd0);
`else
  assign push = accept;
`endif

  assign count_d  = count_q + CW'(push) - CW'(pop_n);
  assign o_count  = count_q;
  assign o_start  = start_q;
  assign o_finish = finish_q;
  assign o_addr   = grp_addr_q;
  assign o_w      = grp_w_q;
  assign o_ia     = grp_ia_q;

  // Issue decision in S_IDLE: full group, padded partial group, or drain done.
  always_comb begin
    load     = 1'b0;
    pop_n    = 2'd0;
    fin_fire = 1'b0;
    if (state_q == S_IDLE) begin
      if (count_q >= CW'(3)) begin
        load  = 1'b1;
        pop_n = 2'd3;
      end else if (flush_eff && (count_q != '0)) begin
        load  = 1'b1;
        pop_n = count_q[1:0];
      end else if (flush_eff && !push && !finish_q) begin
        // finish_q guard keeps the pulse one cycle wide while flush_pend clears
        fin_fire = 1'b1;
      end
    end
  end

  // Peek the three oldest entries and build the next group, padding unused slots.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_addr[k] = mem_addr[rd_ptr_q + PW'(k)];
      rd_w[k]    = mem_w[rd_ptr_q + PW'(k)];
      rd_ia[k]   = mem_ia[rd_ptr_q + PW'(k)];
    end
    last_addr = (pop_n == 2'd2) ? rd_addr[1] : rd_addr[0];
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < pop_n) begin
        grp_addr_d[k] = rd_addr[k];
        grp_w_d[k]    = rd_w[k];
        grp_ia_d[k]   = rd_ia[k];
      end else begin
        grp_addr_d[k] = last_addr;
        grp_w_d[k]    = 16'd0;
        grp_ia_d[k]   = 16'd0;
      end
    end
  end

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= i_addr;
      mem_w[wr_ptr_q]    <= i_w;
      mem_ia[wr_ptr_q]   <= i_ia;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      rd_ptr_q <= rd_ptr_q + PW'(pop_n);
      count_q  <= count_d;
    end
  end

  // Issue FSM with registered start/finish pulses, flush flag and group registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      finish_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        grp_addr_q[k] <= '0;
        grp_w_q[k]    <= '0;
        grp_ia_q[k]   <= '0;
      end
    end else begin
      start_q  <= 1'b0;
      finish_q <= fin_fire;
      if (finish_q) begin
        flush_pend_q <= 1'b0;
      end else if (i_flush) begin
        flush_pend_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (load) begin
            grp_addr_q <= grp_addr_d;
            grp_w_q    <= grp_w_d;
            grp_ia_q   <= grp_ia_d;
            start_q    <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (i_red_finish) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_triplet_feeder.sv
//------------------------------------------------------------------------------
// tb_pe_triplet_feeder
//   Directed bench for pe_triplet_feeder: a cycle table covering group issue,
//   flush with padding and empty flush, plus hand sequences for zero-valued
//   entries, FIFO back-pressure and asynchronous reset in flight.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_triplet_feeder;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [2:0][6:0] i_addr = '0;
  logic [15:0]     i_w = '0;
  logic [15:0]     i_ia = '0;
  logic            i_flush = 1'b0;
  logic            o_start;
  logic [2:0][6:0] o_addr [0:2];
  logic [15:0]     o_w    [0:2];
  logic [15:0]     o_ia   [0:2];
  logic            i_red_finish = 1'b0;
  logic            o_finish;
  logic [CW-1:0]   o_count;

  always #5 clk = ~clk;

  pe_triplet_feeder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_addr       (i_addr),
    .i_w          (i_w),
    .i_ia         (i_ia),
    .i_flush      (i_flush),
    .o_start      (o_start),
    .o_addr       (o_addr),
    .o_w          (o_w),
    .o_ia         (o_ia),
    .i_red_finish (i_red_finish),
    .o_finish     (o_finish),
    .o_count      (o_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic            v;
    logic [2:0][6:0] a;
    logic [15:0]     w;
    logic [15:0]     ia;
    logic            fl;
    logic            rf;
    logic            e_start;
    logic            e_fin;
    logic            e_rdy;
    logic [3:0]      e_cnt;
  } row_t;

  row_t rows [19];

  function automatic logic [2:0][6:0] mk(input logic [6:0] a0, input logic [6:0] a1,
                                         input logic [6:0] a2);
    logic [2:0][6:0] r;
    r[0] = a0;
    r[1] = a1;
    r[2] = a2;
    return r;
  endfunction

  function automatic row_t R(input logic v, input logic [2:0][6:0] a, input logic [15:0] w,
                             input logic [15:0] ia, input logic fl, input logic rf,
                             input logic es, input logic ef, input logic er,
                             input logic [3:0] ec);
    row_t r;
    r.v = v; r.a = a; r.w = w; r.ia = ia; r.fl = fl; r.rf = rf;
    r.e_start = es; r.e_fin = ef; r.e_rdy = er; r.e_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_grp(input string nm,
                         input logic [2:0][6:0] a0, input logic [2:0][6:0] a1,
                         input logic [2:0][6:0] a2,
                         input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                         input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
    logic [2:0][6:0] ea [3];
    logic [15:0]     ew [3];
    logic [15:0]     ex [3];
    ea[0] = a0; ea[1] = a1; ea[2] = a2;
    ew[0] = w0; ew[1] = w1; ew[2] = w2;
    ex[0] = x0; ex[1] = x1; ex[2] = x2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s addr%0d", nm, k), 32'(o_addr[k]), 32'(ea[k]));
      chk($sformatf("%s w%0d", nm, k), 32'(o_w[k]), 32'(ew[k]));
      chk($sformatf("%s ia%0d", nm, k), 32'(o_ia[k]), 32'(ex[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0][6:0] a, input logic [15:0] w,
                       input logic [15:0] ia, input logic fl, input logic rf);
    i_valid = v; i_addr = a; i_w = w; i_ia = ia; i_flush = fl; i_red_finish = rf;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick();
      chk($sformatf("row%0d start", i), 32'(o_start), 32'(rows[i].e_start));
      chk($sformatf("row%0d finish", i), 32'(o_finish), 32'(rows[i].e_fin));
      chk($sformatf("row%0d ready", i), 32'(o_ready), 32'(rows[i].e_rdy));
      chk($sformatf("row%0d count", i), 32'(o_count), 32'(rows[i].e_cnt));
      drive(rows[i].v, rows[i].a, rows[i].w, rows[i].ia, rows[i].fl, rows[i].rf);
    end
  endtask

`ifdef FEEDER_ZERO_SKIP_EN
  localparam int ZS_WAIT = 2;
  localparam int ZS_CNT  = 0;
  localparam int ZS_W0 = 4, ZS_W1 = 5, ZS_W2 = 6, ZS_A0 = 1;
`else
  localparam int ZS_WAIT = 1;
  localparam int ZS_CNT  = 1;
  localparam int ZS_W0 = 0, ZS_W1 = 4, ZS_W2 = 5, ZS_A0 = 0;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [2:0][6:0] A1;
    logic [2:0][6:0] A2;
    logic [2:0][6:0] Z;
    logic [15:0]     ws [4];
    int              peak;
    int              waited;
    int              got;
    int              acc;
    int              idx;

    A1 = mk(7'd1, 7'd2, 7'd3);
    A2 = mk(7'd0, 7'd0, 7'd5);
    Z  = '0;

    //           v     a   w   ia fl rf | st fin rdy cnt
    rows[0]  = R(1'b1, A1, 2,  3, 0, 0,   0, 0, 1, 0);
    rows[1]  = R(1'b1, A1, 2,  3, 0, 0,   0, 0, 1, 1);
    rows[2]  = R(1'b1, A1, 2,  3, 0, 0,   0, 0, 1, 2);
    rows[3]  = R(1'b0, Z,  0,  0, 0, 0,   0, 0, 1, 3);
    rows[4]  = R(1'b0, Z,  0,  0, 0, 0,   1, 0, 1, 0);
    rows[5]  = R(1'b0, Z,  0,  0, 0, 0,   0, 0, 1, 0);
    rows[6]  = R(1'b0, Z,  0,  0, 0, 1,   0, 0, 1, 0);
    rows[7]  = R(1'b0, Z,  0,  0, 0, 0,   0, 0, 1, 0);
    rows[8]  = R(1'b1, A2, 7,  9, 0, 0,   0, 0, 1, 0);
    rows[9]  = R(1'b0, Z,  0,  0, 1, 0,   0, 0, 1, 1);
    rows[10] = R(1'b0, Z,  0,  0, 0, 0,   1, 0, 0, 0);
    rows[11] = R(1'b0, Z,  0,  0, 0, 0,   0, 0, 0, 0);
    rows[12] = R(1'b0, Z,  0,  0, 0, 1,   0, 0, 0, 0);
    rows[13] = R(1'b0, Z,  0,  0, 0, 0,   0, 0, 0, 0);
    rows[14] = R(1'b0, Z,  0,  0, 0, 0,   0, 1, 0, 0);
    rows[15] = R(1'b0, Z,  0,  0, 0, 0,   0, 0, 1, 0);
    rows[16] = R(1'b0, Z,  0,  0, 1, 0,   0, 0, 1, 0);
    rows[17] = R(1'b0, Z,  0,  0, 0, 0,   0, 1, 0, 0);
    rows[18] = R(1'b0, Z,  0,  0, 0, 0,   0, 0, 1, 0);

    // reset state
    tick();
    tick();
    chk("reset start", 32'(o_start), 32'd0);
    chk("reset finish", 32'(o_finish), 32'd0);
    chk("reset count", 32'(o_count), 32'd0);
    chk("reset ready", 32'(o_ready), 32'd0);
    chk_grp("reset grp", Z, Z, Z, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("post-reset ready", 32'(o_ready), 32'd1);

    // full group, flush with padding, empty flush
    run_rows(0, 4);
    chk_grp("grp1", A1, A1, A1, 2, 2, 2, 3, 3, 3);
    run_rows(5, 10);
    chk_grp("grp flush", A2, A2, A2, 7, 0, 0, 9, 0, 0);
    run_rows(11, 18);
    chk_grp("grp hold", A2, A2, A2, 7, 0, 0, 9, 0, 0);

    // entries with a zero weight
    ws[0] = 16'd0; ws[1] = 16'd4; ws[2] = 16'd5; ws[3] = 16'd6;
    peak = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (int'(o_count) > peak) peak = int'(o_count);
      drive(1'b1, mk(7'(j), 7'd0, 7'd0), ws[j], 16'd1, 1'b0, 1'b0);
    end
    got = 0;
    waited = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      waited++;
      if (int'(o_count) > peak) peak = int'(o_count);
      drive(1'b0, Z, 16'd0, 16'd0, 1'b0, 1'b0);
      if (o_start) begin
        got = 1;
        break;
      end
    end
    chk("zs start seen", 32'(got), 32'd1);
    chk("zs start latency", 32'(waited), 32'(ZS_WAIT));
    chk("zs peak count", 32'(peak), 32'd3);
    chk("zs count at start", 32'(o_count), 32'(ZS_CNT));
    chk_grp("zs grp", mk(7'(ZS_A0), 0, 0), mk(7'(ZS_A0 + 1), 0, 0), mk(7'(ZS_A0 + 2), 0, 0),
            16'(ZS_W0), 16'(ZS_W1), 16'(ZS_W2), 1, 1, 1);

    // clean restart
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // back-pressure: finish held low, valid held high
    acc = 0;
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (c == 4) begin
        chk("bp first start", 32'(o_start), 32'd1);
        chk_grp("bp grp1", mk(0, 1, 2), mk(1, 2, 3), mk(2, 3, 4), 0, 1, 2, 100, 101, 102);
      end
      if (c == 11) begin
        chk("bp count full", 32'(o_count), 32'd8);
        chk("bp ready full", 32'(o_ready), 32'd0);
      end
      drive(1'b1, mk(7'(idx), 7'(idx + 1), 7'(idx + 2)), 16'(idx), 16'(100 + idx),
            1'b0, (c == 13) ? 1'b1 : 1'b0);
      if (o_ready) begin
        acc++;
        idx++;
      end
    end
    chk("bp accepted", 32'(acc), 32'd11);
    tick();
    chk("bp idle ready", 32'(o_ready), 32'd0);
    chk("bp idle count", 32'(o_count), 32'd8);
    drive(1'b0, Z, 16'd0, 16'd0, 1'b0, 1'b0);
    tick();
    chk("bp second start", 32'(o_start), 32'd1);
    chk("bp count after pop", 32'(o_count), 32'd5);
    chk("bp ready after pop", 32'(o_ready), 32'd1);
    chk_grp("bp grp2", mk(3, 4, 5), mk(4, 5, 6), mk(5, 6, 7), 3, 4, 5, 103, 104, 105);

    // asynchronous reset while waiting on the reducer
    tick();
    chk("wait count", 32'(o_count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst start", 32'(o_start), 32'd0);
    chk("async rst finish", 32'(o_finish), 32'd0);
    chk("async rst count", 32'(o_count), 32'd0);
    chk_grp("async rst grp", Z, Z, Z, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst release ready", 32'(o_ready), 32'd1);
    tick();
    chk("rst release count", 32'(o_count), 32'd0);
    chk("rst release no start", 32'(o_start), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
